// File: rtl/multi_sw_debouncer.sv
// N-channel push-button debouncer: synchronisers, polarity fold, debounce counters,
// registered press/release pulses, single-shot long-press detection and an any-pressed summary.
module multi_sw_debouncer #(
  parameter int NUM_CH      = 8,
  parameter int CNT_W       = 17,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int HOLD_W      = 25
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] PB,
  output logic [NUM_CH-1:0] DEBOUNCED,
  output logic [NUM_CH-1:0] PB_DOWN,
  output logic [NUM_CH-1:0] PB_UP,
  output logic [NUM_CH-1:0] PB_HOLD,
  output logic              ANY_PRESSED
);

  localparam logic [NUM_CH-1:0] RELEASED = (ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] lvl;
  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [HOLD_W-1:0] hcnt   [NUM_CH];
  logic [NUM_CH-1:0] done;

  // Synchronisers reset to the released pin level so reset never looks like a press.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RELEASED;
    end else begin
      sync_q[0] <= PB;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign lvl = sync_q[SYNC_STAGES-1] ^ RELEASED;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      DEBOUNCED <= '0;
      PB_DOWN   <= '0;
      PB_UP     <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      PB_DOWN <= '0;
      PB_UP   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (DEBOUNCED[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != {CNT_W{1'b1}}) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else begin
          // Stable for the full window: toggle and report the direction.
          cnt[i]       <= '0;
          DEBOUNCED[i] <= ~DEBOUNCED[i];
          PB_DOWN[i]   <= ~DEBOUNCED[i];
          PB_UP[i]     <= DEBOUNCED[i];
        end
      end
    end
  end

  // The hold counter parks at all-ones once done is set, so it fires once per press.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PB_HOLD <= '0;
      done    <= '0;
      for (int i = 0; i < NUM_CH; i++) hcnt[i] <= '0;
    end else begin
      PB_HOLD <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!DEBOUNCED[i]) begin
          hcnt[i] <= '0;
          done[i] <= 1'b0;
        end else if (!done[i]) begin
          if (hcnt[i] == {HOLD_W{1'b1}}) begin
            PB_HOLD[i] <= 1'b1;
            done[i]    <= 1'b1;
          end else begin
            hcnt[i] <= hcnt[i] + HOLD_ONE;
          end
        end
      end
    end
  end

  assign ANY_PRESSED = |DEBOUNCED;

endmodule

// File: tb/tb_multi_sw_debouncer.sv
// Scoreboarded random/directed bench for multi_sw_debouncer; the reference model counts
// consecutive mismatch and pressed cycles per channel and queues the pulses it predicts.
module tb_multi_sw_debouncer;

  localparam int N      = 4;
  localparam int CW     = 4;
  localparam int HW     = 6;
  localparam int SS     = 2;
  localparam int AL     = 1;
  localparam int DEB_T  = 1 << CW;
  localparam int HOLD_T = 1 << HW;

  logic         CLK   = 1'b0;
  logic         RESET = 1'b0;
  logic [N-1:0] PB    = 4'b1110;
  logic [N-1:0] DEBOUNCED, PB_DOWN, PB_UP, PB_HOLD;
  logic         ANY_PRESSED;

  always #5 CLK = ~CLK;

  multi_sw_debouncer #(
    .NUM_CH(N), .CNT_W(CW), .SYNC_STAGES(SS), .ACTIVE_LOW(AL), .HOLD_W(HW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PB(PB), .DEBOUNCED(DEBOUNCED), .PB_DOWN(PB_DOWN),
    .PB_UP(PB_UP), .PB_HOLD(PB_HOLD), .ANY_PRESSED(ANY_PRESSED)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] down;
    logic [N-1:0] up;
    logic [N-1:0] hold;
    logic [N-1:0] deb;
  } ev_t;

  ev_t exp_q[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  // Reference model state: pin history, debounced level, run lengths.
  logic [N-1:0] m_pipe [SS];
  logic [N-1:0] m_deb;
  int           m_run   [N];
  int           m_held  [N];
  bit           m_fired [N];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic model_reset();
    for (int s = 0; s < SS; s++) m_pipe[s] = (AL != 0) ? '1 : '0;
    m_deb = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_held[i] = 0; m_fired[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] lvl, nd;
    ev_t e;
    lvl    = m_pipe[SS-1] ^ ((AL != 0) ? 4'b1111 : 4'b0000);
    nd     = m_deb;
    e.down = '0; e.up = '0; e.hold = '0;
    for (int i = 0; i < N; i++) begin
      if (m_deb[i]) begin
        if (!m_fired[i]) begin
          m_held[i]++;
          if (m_held[i] == HOLD_T) begin
            e.hold[i]  = 1'b1;
            m_fired[i] = 1'b1;
          end
        end
      end else begin
        m_held[i]  = 0;
        m_fired[i] = 1'b0;
      end
      if (lvl[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB_T) begin
          m_run[i] = 0;
          nd[i]    = lvl[i];
          if (lvl[i]) e.down[i] = 1'b1;
          else        e.up[i]   = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_deb = nd;
    for (int s = SS - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
    m_pipe[0] = PB;
    e.deb = m_deb;
    e.cyc = cyc + 1;
    if (|{e.down, e.up, e.hold}) exp_q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET) model_reset();
      else        model_step();
    end
  end

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
    end
  endtask

  // Monitor: levels every cycle, pulses matched against the queued predictions.
  initial begin
    ev_t e;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        total++; bad++;
        $display("FAIL missed_pulse cyc=%0d got=none want down=%b up=%b hold=%b",
                 e.cyc, e.down, e.up, e.hold);
      end
      if (|{PB_DOWN, PB_UP, PB_HOLD}) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          total++; bad++;
          $display("FAIL unexpected_pulse cyc=%0d got down=%b up=%b hold=%b want=none",
                   cyc, PB_DOWN, PB_UP, PB_HOLD);
        end else begin
          e = exp_q.pop_front();
          chk("pb_down", PB_DOWN, e.down);
          chk("pb_up", PB_UP, e.up);
          chk("pb_hold", PB_HOLD, e.hold);
          chk("deb_at_event", DEBOUNCED, e.deb);
        end
      end
      chk("debounced", DEBOUNCED, m_deb);
      chk("any_pressed", {3'b000, ANY_PRESSED}, {3'b000, |m_deb});
    end
  end

  task automatic drive(input logic [N-1:0] v, input int n);
    PB = v;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_debounced", DEBOUNCED, '0);
    chk("rst_pb_down", PB_DOWN, '0);
    chk("rst_pb_up", PB_UP, '0);
    chk("rst_pb_hold", PB_HOLD, '0);
    chk("rst_any", {3'b000, ANY_PRESSED}, 4'b0000);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #1 RESET = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1 RESET = 1'b1;
  endtask

  initial begin
    logic [N-1:0] v;
    int           len;
    #2 check_reset_outputs();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1 RESET = 1'b1;
    drive(4'b1110, 30);
    // Clean press and release on ch1
    drive(4'b1100, 30); drive(4'b1110, 30);
    // Bounce then glitch on ch2
    drive(4'b1010, 10); drive(4'b1110, 1); drive(4'b1010, 30);
    drive(4'b1110, 8);  drive(4'b1010, 30); drive(4'b1110, 30);
    // Long press on ch3, then releases just short of and exactly at the hold time
    drive(4'b0110, 100); drive(4'b1110, 30);
    drive(4'b0110, 63);  drive(4'b1110, 30);
    drive(4'b0110, 64);  drive(4'b1110, 30);
    // Simultaneous press of ch0 and ch2
    drive(4'b1111, 30); drive(4'b1010, 30); drive(4'b1111, 30);
    // Reset while ch3 is pressed and ch1 is mid-debounce
    drive(4'b0111, 30); drive(4'b0101, 10);
    do_reset();
    drive(4'b0101, 30); drive(4'b1111, 100);
    // Random toggling with short glitches, normal presses and long holds
    repeat (150) begin
      v = PB ^ 4'($urandom_range(1, 15));
      case ($urandom_range(0, 2))
        0:       len = $urandom_range(1, DEB_T - 1);
        1:       len = $urandom_range(DEB_T, 40);
        default: len = $urandom_range(60, 90);
      endcase
      drive(v, len);
      if ($urandom_range(0, 19) == 0) do_reset();
    end
    drive(4'b1111, 100);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
